maxpool_window_feeder: RTL

MAXPOOL_WINDOW_FEEDER -- requirements
Module: maxpool_window_feeder

---
 rtl/maxpool_window_feeder_if.sv | 29 ++
 rtl/maxpool_window_feeder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/maxpool_window_feeder_if.sv
// Control, input stream and window-output stream of the maxpool window feeder.
// The DUT takes the slave modport; the master modport is for whatever drives it.
interface maxpool_window_feeder_if #(
  parameter int W_BITS = 7
);
  logic              start;
  logic [W_BITS-1:0] cfg_width;
  logic [W_BITS-1:0] cfg_height;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic              out_first;
  logic              out_last;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_width, cfg_height, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last, busy, done
  );

  modport slave (
    input  start, cfg_width, cfg_height, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last, busy, done
  );
endinterface

// File: rtl/maxpool_window_feeder.sv
// Turns a row-major Qint8 stream into 2x2 max-pool windows: the top row of
// each row pair is buffered, and the bottom row is paired against it.
//
// state | meaning
// IDLE  | waiting for start; invalid configs pulse done from here
// FILL0 | writing the top row of a row pair into the line buffer
// FILL1 | taking bottom-row elements: even column -> H, odd column -> L
// EMIT  | presenting linebuf[c], linebuf[c+1], H, L to the comparator
module maxpool_window_feeder #(
  parameter int MAX_W  = 64,
  parameter int W_BITS = 7
) (
  input logic                    clk,
  input logic                    rst,
  maxpool_window_feeder_if.slave bus
);
  localparam int AW = $clog2(MAX_W);
  localparam logic [W_BITS:0]   MAX_W_L  = (W_BITS + 1)'(MAX_W);
  localparam logic [W_BITS-1:0] ONE      = W_BITS'(1);
  localparam logic [W_BITS-1:0] TWO      = W_BITS'(2);
  localparam logic [W_BITS-1:0] EVEN_MSK = ~ONE;

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, EMIT} state_t;

  state_t            state, state_n;
  logic [W_BITS-1:0] width_q, height_q, col, row;
  logic [1:0]        elem;
  logic [7:0]        h_q, l_q;
  logic              done_q;
  logic [7:0]        linebuf [MAX_W];

  logic [W_BITS-1:0] w_mask, h_mask;
  logic              cfg_ok, col_last, row_last;
  logic [AW-1:0]     lb_idx, lb_even;
  logic              in_ready_c, out_valid_c, out_first_c, out_last_c;
  logic [7:0]        out_data_c;

  assign w_mask   = bus.cfg_width & EVEN_MSK;
  assign h_mask   = bus.cfg_height & EVEN_MSK;
  assign cfg_ok   = (w_mask != '0) && (h_mask != '0) && ({1'b0, w_mask} <= MAX_W_L);
  assign col_last = (col + ONE) == width_q;
  assign row_last = (row + TWO) == height_q;
  // In EMIT col sits on the odd column of the window, so the pair is {col&~1, col}.
  assign lb_idx   = col[AW-1:0];
  assign lb_even  = {lb_idx[AW-1:1], 1'b0};

  always_comb begin
    state_n     = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_first_c = 1'b0;
    out_last_c  = 1'b0;
    out_data_c  = 8'h00;
    case (state)
      IDLE: begin
        if (bus.start && cfg_ok) state_n = FILL0;
      end
      FILL0: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && col_last) state_n = FILL1;
      end
      FILL1: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && col[0]) state_n = EMIT;
      end
      EMIT: begin
        out_valid_c = 1'b1;
        case (elem)
          2'd0: begin out_data_c = linebuf[lb_even]; out_first_c = 1'b1; end
          2'd1: out_data_c = linebuf[lb_idx];
          2'd2: out_data_c = h_q;
          default: begin out_data_c = l_q; out_last_c = 1'b1; end
        endcase
        if (bus.out_ready && elem == 2'd3) begin
          if (!col_last)     state_n = FILL1;
          else if (row_last) state_n = IDLE;
          else               state_n = FILL0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      col      <= '0;
      row      <= '0;
      elem     <= '0;
      h_q      <= '0;
      l_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            done_q   <= !cfg_ok;
            width_q  <= w_mask;
            height_q <= h_mask;
            col      <= '0;
            row      <= '0;
            elem     <= '0;
          end
        end
        FILL0: begin
          if (bus.in_valid) col <= col_last ? '0 : col + ONE;
        end
        FILL1: begin
          if (bus.in_valid) begin
            if (!col[0]) begin
              h_q <= bus.in_data;
              col <= col + ONE;
            end else begin
              l_q  <= bus.in_data;
              elem <= '0;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            elem <= elem + 2'd1;
            if (elem == 2'd3) begin
              if (!col_last) begin
                col <= col + ONE;
              end else begin
                col <= '0;
                if (row_last) done_q <= 1'b1;
                else          row    <= row + TWO;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer has no reset; its contents only matter after a full FILL0 pass.
  always_ff @(posedge clk) begin
    if (rst && state == FILL0 && bus.in_valid) linebuf[lb_idx] <= bus.in_data;
  end

  assign bus.in_ready  = rst && in_ready_c;
  assign bus.out_valid = rst && out_valid_c;
  assign bus.out_first = rst && out_first_c;
  assign bus.out_last  = rst && out_last_c;
  assign bus.out_data  = rst ? out_data_c : 8'h00;
  assign bus.busy      = rst && (state != IDLE);
  assign bus.done      = rst && done_q;
endmodule
